// File: rtl/calc_pkg.sv
// Shared ISA constants, ALU operation enum and ALU/sign-extend helpers for calc_core.
package calc_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_SLT     = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc_if.sv
// Observation bus of calc_core: fetch address, fetched word, halt flag and $2.
interface calc_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halted;
    logic [31:0] v0;

    modport master (output pc, output instr, output halted, output v0);
    modport slave  (input  pc, input  instr, input  halted, input  v0);
endinterface

// File: rtl/calc_mem.sv
// Word RAM, combinational read, write on posedge; contents are never reset.
// Byte address in, low two bits ignored, index wraps modulo WORDS.
module calc_mem #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdat_i,
    output logic [31:0] rdat_o
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] idx;

    wire unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign idx    = addr_i[AW+1:2];
    assign rdat_o = mem[idx];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx] <= wdat_i;
        end
    end
endmodule

// File: rtl/calc_core.sv
// Single-cycle MIPS-32 subset core; one instruction retires per clk edge.
// No stalls: after syscall pc, registers and data memory freeze until reset.
module calc_core
    import calc_pkg::*;
#(
    parameter int          IMEM_WORDS = 4096,
    parameter int          DMEM_WORDS = 4096,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    calc_if.master bus
);
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] pc_d;

    logic [31:0] regs_q [32];
    logic        halted_q;
    logic        halted_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;
    logic [31:0] simm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] dmem_rdat;
    logic [31:0] wb_dat;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        mem_we;
    logic        wb_mem;
    alu_op_e     alu_op;

    wire unused_shamt = ^instr[10:6];

    if (1'b1) begin : fetchunit
        logic [31:0] PCout;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                PCout <= RESET_PC;
            end else if (!halted_q) begin
                PCout <= pc_d;
            end
        end
    end

    assign pc = fetchunit.PCout;

    calc_mem #(.WORDS(IMEM_WORDS)) instMem (
        .clk    (clk),
        .we_i   (1'b0),
        .addr_i (pc),
        .wdat_i (32'h0),
        .rdat_o (instr)
    );

    calc_mem #(.WORDS(DMEM_WORDS)) memory0 (
        .clk    (clk),
        .we_i   (mem_we && !halted_q),
        .addr_i (alu_res),
        .wdat_i (rt_val),
        .rdat_o (dmem_rdat)
    );

    assign opcode   = instr[31:26];
    assign rs_a     = instr[25:21];
    assign rt_a     = instr[20:16];
    assign rd_a     = instr[15:11];
    assign funct    = instr[5:0];
    assign simm     = sext16(instr[15:0]);
    assign pc_plus4 = pc + 32'd4;

    // $0 is forced to zero on read so it holds even before the first reset.
    assign rs_val  = (rs_a == 5'd0) ? 32'h0 : regs_q[rs_a];
    assign rt_val  = (rt_a == 5'd0) ? 32'h0 : regs_q[rt_a];
    assign alu_res = alu(alu_op, rs_val, alu_b);
    assign wb_dat  = wb_mem ? dmem_rdat : alu_res;

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = rd_a;
        alu_op   = ALU_ADD;
        alu_b    = rt_val;
        mem_we   = 1'b0;
        wb_mem   = 1'b0;
        halted_d = 1'b0;
        pc_d     = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: wr_en = 1'b1;
                    F_SUB: begin wr_en = 1'b1; alu_op = ALU_SUB; end
                    F_AND: begin wr_en = 1'b1; alu_op = ALU_AND; end
                    F_OR:  begin wr_en = 1'b1; alu_op = ALU_OR;  end
                    F_SLT: begin wr_en = 1'b1; alu_op = ALU_SLT; end
                    F_SYSCALL: begin
                        halted_d = 1'b1;
                        pc_d     = pc;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                wr_en   = 1'b1;
                wr_addr = rt_a;
                alu_b   = simm;
            end
            OP_LW: begin
                wr_en   = 1'b1;
                wr_addr = rt_a;
                alu_b   = simm;
                wb_mem  = 1'b1;
            end
            OP_SW: begin
                mem_we = 1'b1;
                alu_b  = simm;
            end
            OP_BEQ: if (rs_val == rt_val) pc_d = pc_plus4 + (simm << 2);
            OP_BNE: if (rs_val != rt_val) pc_d = pc_plus4 + (simm << 2);
            OP_J:   pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            halted_q <= halted_d;
            if (wr_en && (wr_addr != 5'd0)) begin
                regs_q[wr_addr] <= wb_dat;
            end
        end
    end

    assign bus.pc     = pc;
    assign bus.instr  = instr;
    assign bus.halted = halted_q;
    assign bus.v0     = regs_q[2];
endmodule

// File: tb/tb_calc_core.sv
// Directed and random programs for calc_core, checked against an ISA-level interpreter.
module tb_calc_core;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    calc_if bus ();

    calc_core #(
        .IMEM_WORDS (4096),
        .DMEM_WORDS (4096),
        .RESET_PC   (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_imem [4096];
    logic [31:0] m_dmem [4096];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] prog [$];

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic int pick_reg();
        int t;
        t = $urandom_range(0, 4);
        case (t)
            0: return 0;
            1: return 2;
            2: return 8;
            3: return 9;
            default: return 10;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put_i(input int widx, input logic [31:0] w);
        m_imem[widx] = w;
        dut.instMem.mem[widx] = w;
    endtask

    task automatic put_d(input int widx, input logic [31:0] w);
        m_dmem[widx] = w;
        dut.memory0.mem[widx] = w;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 4096; i++) put_i(i, 32'h0);
        foreach (prog[i]) put_i(i, prog[i]);
        prog.delete();
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    // Architectural effect of executing the instruction at m_pc.
    task automatic model_step();
        logic [31:0] ins, a, b, simm, ea, npc;
        int rs, rt, rd, dst;
        logic [31:0] res;
        logic wr;
        if (m_halted) return;
        ins  = m_imem[m_pc[13:2]];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = m_regs[rs];
        b    = m_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        ea   = a + simm;
        npc  = m_pc + 32'd4;
        wr   = 1'b0;
        dst  = 0;
        res  = 32'h0;
        case (int'(ins[31:26]))
            'h00: begin
                dst = rd;
                case (int'(ins[5:0]))
                    'h20: begin wr = 1'b1; res = a + b; end
                    'h22: begin wr = 1'b1; res = a - b; end
                    'h24: begin wr = 1'b1; res = a & b; end
                    'h25: begin wr = 1'b1; res = a | b; end
                    'h2A: begin wr = 1'b1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    'h0C: begin m_halted = 1'b1; npc = m_pc; end
                    default: ;
                endcase
            end
            'h08: begin wr = 1'b1; dst = rt; res = ea; end
            'h23: begin wr = 1'b1; dst = rt; res = m_dmem[ea[13:2]]; end
            'h2B: m_dmem[ea[13:2]] = b;
            'h04: if (a == b) npc = m_pc + 32'd4 + (simm << 2);
            'h05: if (a != b) npc = m_pc + 32'd4 + (simm << 2);
            'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr && dst != 0) m_regs[dst] = res;
        m_pc = npc;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check({tag, "_pc"}, bus.pc, m_pc);
        check({tag, "_v0"}, bus.v0, m_regs[2]);
        check({tag, "_halted"}, {31'b0, bus.halted}, {31'b0, m_halted});
        check({tag, "_instr"}, bus.instr, m_imem[m_pc[13:2]]);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_rst_pc"}, bus.pc, 32'h0);
        check({tag, "_rst_halted"}, {31'b0, bus.halted}, 32'h0);
        check({tag, "_rst_v0"}, bus.v0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) put_d(i, 32'h0);

        // Reset and basic add, then halt freezes pc.
        prog = {enc_i(6'h08, 0, 8, 16'd5), enc_i(6'h08, 0, 9, 16'd7),
                enc_r(8, 9, 2, 6'h20), 32'h0000_000C};
        load_prog();
        do_reset("t1");
        for (int i = 0; i < 3; i++) step("t1");
        check("t1_v0_is_12", bus.v0, 32'd12);
        step("t1");
        check("t1_halted", {31'b0, bus.halted}, 32'd1);
        check("t1_pc_frozen", bus.pc, 32'h0C);
        step("t1h");
        step("t1h");
        check("t1_pcout", dut.fetchunit.PCout, 32'h0C);

        // Wrapping arithmetic, slt, sub, and, or.
        prog = {enc_i(6'h08, 0, 8, 16'hFFFF), enc_r(8, 8, 2, 6'h20),
                enc_r(8, 0, 2, 6'h2A), enc_i(6'h08, 0, 9, 16'd1),
                enc_r(0, 9, 2, 6'h22), enc_r(8, 9, 2, 6'h24),
                enc_r(9, 0, 2, 6'h25), 32'h0000_000C};
        load_prog();
        do_reset("t2");
        step("t2");
        step("t2");
        check("t2_wrap", bus.v0, 32'hFFFF_FFFE);
        step("t2");
        check("t2_slt", bus.v0, 32'd1);
        step("t2");
        step("t2");
        check("t2_sub", bus.v0, 32'hFFFF_FFFF);
        step("t2");
        check("t2_and", bus.v0, 32'd1);
        for (int i = 0; i < 3; i++) step("t2");

        // Load/increment/store through the data segment.
        put_d(2048, 32'h11);
        prog = {enc_i(6'h08, 0, 8, 16'h2000), enc_i(6'h23, 8, 9, 16'd0),
                enc_i(6'h08, 9, 9, 16'd1), enc_i(6'h2B, 8, 9, 16'd4), 32'h0000_000C};
        load_prog();
        do_reset("t3");
        for (int i = 0; i < 6; i++) step("t3");
        check("t3_mem2049", dut.memory0.mem[2049], 32'h12);

        // Branches, jump, unknown opcode, $0 protection.
        prog.delete();
        load_prog();
        put_i(0,  enc_i(6'h08, 0, 8, 16'd1));
        put_i(1,  enc_i(6'h08, 0, 2, 16'd3));
        put_i(2,  enc_i(6'h04, 8, 8, 16'd2));
        put_i(3,  enc_i(6'h08, 0, 2, 16'd99));
        put_i(4,  enc_i(6'h08, 0, 2, 16'd98));
        put_i(5,  enc_i(6'h05, 8, 8, 16'd5));
        put_i(6,  {6'h02, 26'h10});
        put_i(16, 32'hFC00_0000);
        put_i(17, enc_i(6'h08, 0, 0, 16'd9));
        put_i(18, enc_r(0, 0, 2, 6'h20));
        put_i(19, 32'h0000_000C);
        do_reset("t4");
        step("t4");
        step("t4");
        step("t4");
        check("t4_beq_taken", bus.pc, 32'h14);
        step("t4");
        check("t4_bne_not", bus.pc, 32'h18);
        step("t4");
        check("t4_jump", bus.pc, 32'h40);
        step("t4");
        check("t4_unknown_op", bus.pc, 32'h44);
        check("t4_v0_kept", bus.v0, 32'd3);
        step("t4");
        step("t4");
        check("t4_zero_reg", bus.v0, 32'h0);
        step("t4");
        step("t4");

        // Asynchronous reset mid-run, between clock edges.
        prog = {enc_i(6'h08, 0, 2, 16'h55), enc_i(6'h2B, 0, 2, 16'h2000)};
        for (int i = 0; i < 6; i++) prog.push_back(enc_i(6'h08, 2, 2, 16'd1));
        prog.push_back(32'h0000_000C);
        load_prog();
        do_reset("t5");
        for (int i = 0; i < 8; i++) step("t5");
        check("t5_pc_at_20", bus.pc, 32'h20);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("t5_async_pc", bus.pc, 32'h0);
        check("t5_async_halted", {31'b0, bus.halted}, 32'h0);
        check("t5_async_v0", bus.v0, 32'h0);
        check("t5_dmem_kept", dut.memory0.mem[2048], 32'h55);
        check("t5_imem_kept", dut.instMem.mem[0], enc_i(6'h08, 0, 2, 16'h55));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step("t5r");
        check("t5_rerun_v0", bus.v0, 32'h5B);
        check("t5_rerun_halt", {31'b0, bus.halted}, 32'd1);

        // Random programs against the interpreter.
        for (int p = 0; p < 4; p++) begin
            int kind;
            logic [5:0] fn;
            for (int i = 0; i < 24; i++) begin
                kind = $urandom_range(0, 8);
                case (kind)
                    0, 1: prog.push_back(enc_i(6'h08, pick_reg(), pick_reg(),
                                               16'($urandom)));
                    2, 3, 4: begin
                        case ($urandom_range(0, 4))
                            0: fn = 6'h20;
                            1: fn = 6'h22;
                            2: fn = 6'h24;
                            3: fn = 6'h25;
                            default: fn = 6'h2A;
                        endcase
                        prog.push_back(enc_r(pick_reg(), pick_reg(), pick_reg(), fn));
                    end
                    5: prog.push_back(enc_i(6'h2B, 0, pick_reg(),
                                            16'(32'h2000 + 4 * $urandom_range(0, 7))));
                    6: prog.push_back(enc_i(6'h23, 0, pick_reg(),
                                            16'(32'h2000 + 4 * $urandom_range(0, 7))));
                    7: prog.push_back(enc_r(pick_reg(), pick_reg(), 2, 6'h20));
                    default: begin
                        if (i < 20)
                            prog.push_back(enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05,
                                                 pick_reg(), pick_reg(),
                                                 16'($urandom_range(1, 2))));
                        else
                            prog.push_back(enc_i(6'h08, 2, 2, 16'd1));
                    end
                endcase
            end
            prog.push_back(32'h0000_000C);
            load_prog();
            do_reset("rnd");
            for (int i = 0; i < 30; i++) step("rnd");
            check("rnd_halted", {31'b0, bus.halted}, 32'd1);
            for (int w = 2048; w < 2056; w++)
                check($sformatf("rnd_dmem%0d", w), dut.memory0.mem[w], m_dmem[w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
